mtrx_sub_arbiter: RTL

//  Shares one registered 5x5 int8 matrix subtractor (200-bit packed, 25 lanes x 8b,
//  C = A - B per lane, one clock edge of latency) between NUM_REQ requesters.

---
 rtl/mtrx_sub_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mtrx_sub_arbiter.sv
// Round-robin arbiter that shares one registered 5x5 int8 matrix subtractor
// between NUM_REQ requesters, with valid/ready requests and one-cycle responses.
module mtrx_sub_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int MAT_W       = 200,
   parameter int SUB_LATENCY = 1,
   parameter int CNT_W       = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*MAT_W-1:0] req_a,
   input  logic [NUM_REQ*MAT_W-1:0] req_b,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [MAT_W-1:0]         rsp_data,
   output logic [MAT_W-1:0]         sub_a,
   output logic [MAT_W-1:0]         sub_b,
   input  logic [MAT_W-1:0]         sub_c,
   output logic                     busy,
   output logic [CNT_W-1:0]         op_count
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WC_W  = (SUB_LATENCY > 0) ? $clog2(SUB_LATENCY + 1) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(SUB_LATENCY);
   localparam logic [IDX_W-1:0] LAST_REQ  = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [1:0]       state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] owner;
   logic [WC_W-1:0]  wait_cnt;

   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] cand;
   logic             grant_found;
   logic             take;
   logic [MAT_W-1:0] sel_a;
   logic [MAT_W-1:0] sel_b;

   // First valid requester at or above rr_ptr, wrapping around.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign take = (state == ST_IDLE) && grant_found && !reset;

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (grant_idx == IDX_W'(k)) begin
            sel_a = req_a[k*MAT_W +: MAT_W];
            sel_b = req_b[k*MAT_W +: MAT_W];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (take)
         req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      rsp_valid = '0;
      if (state == ST_RESP)
         rsp_valid[owner] = 1'b1;
   end

   assign busy = (state != ST_IDLE);

   // WAIT spans SUB_LATENCY+1 edges: one for the operand registers, the rest
   // for the subtractor pipeline; the last edge captures sub_c.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         wait_cnt <= '0;
         sub_a    <= '0;
         sub_b    <= '0;
         rsp_data <= '0;
         op_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (take) begin
                  sub_a    <= sel_a;
                  sub_b    <= sel_b;
                  owner    <= grant_idx;
                  rr_ptr   <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
                  wait_cnt <= '0;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  rsp_data <= sub_c;
                  state    <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               if (op_count != CNT_MAX)
                  op_count <= op_count + 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
